gate_pipe: RTL and testbench
============================

# gate_pipe

- Parametrised, pipelined N-input bitwise logic gate with a selectable operation and a valid/ready handshake on both sides.
- Successor to the team's single-bit registered AND gate: generalised in operand width, input count and operation, with a configurable pipeline depth and backpressure.
- Sits between a valid/ready producer and consumer.
- The registered output is the intended target for concurrent assertions in the bench.

## Interface

Parameters:

- WIDTH, 8, bit width of each operand and of the result.
- N_IN, 2, number of operands (2..8).
- STAGES, 2, pipeline depth in registers (1..4).

Ports:

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  N_IN*WIDTH  operands; operand k is in_data[k*WIDTH +: WIDTH].
- op  in  3  operation code, sampled with the beat.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  WIDTH  result.
- op_err  out  1  travels with y; set if the beat used a reserved op.
- hit_cnt  out  16  all-ones result count (see Configuration).
- cnt_clr  in  1  synchronous clear of hit_cnt.

## Operation

- Op codes:
  - 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR.
  - Each is a bitwise reduction across all N_IN operands.
  - 110 and 111 are reserved: result is 0 and op_err is 1.
- Operand reduction is combinational. Its result and op_err are captured in stage 0.
- Stages 1..STAGES-1 delay the data.
- Each stage holds {valid, y, op_err}.
- Global advance enable: en = ~out_valid | out_ready.
  - When en=1, every stage shifts forward.
  - Stage 0 loads in_valid together with the computed data.
  - When en=0, all stages hold.
- in_ready = en. A beat is accepted iff in_valid & in_ready.
- Bubbles do not collapse: an invalid stage still consumes a cycle of latency.
- Output stage:
  - out_valid, y and op_err come from the last stage.
  - Holding rule: while out_valid=1 and out_ready=0, y and op_err stay stable.
- Reset (rst_n low, asynchronous):
  - All stage valids, y, op_err and hit_cnt go to 0 immediately.
  - Any beats in flight are discarded.
  - in_ready=1 while in reset.
- Deassertion of rst_n takes effect on the next clk edge. Beats presented in the cycle of deassertion are accepted normally.

## Timing

- Latency: a beat accepted at edge t appears on out_valid/y after edge t+STAGES-1, i.e. STAGES cycles after it is presented, when there is no stall.
- Throughput: one beat per cycle with out_ready held high.
- Stall:
  - out_ready low with out_valid high freezes the whole pipe in the same cycle (in_ready drops combinationally).
  - Resume is lossless and keeps beats in order.
- Simultaneous output transfer and input accept in one cycle is legal and required.
- op changes while in_valid is low have no effect.

## Configuration

Macro GATE_PIPE_STATS_EN.

Defined:

- hit_cnt increments on each output transfer (out_valid & out_ready) with y == all ones and op_err == 0.
- hit_cnt saturates at 16'hFFFF.
- cnt_clr=1 zeroes hit_cnt on the next edge. Clear has priority over increment in the same cycle.

Undefined:

- No counter logic is built.
- hit_cnt is tied to 0 and cnt_clr is ignored.
- The port list is unchanged.

## Test plan

- Reset check: rst_n low, then released with out_ready=1.
  - During reset: out_valid=0, y=0, op_err=0, hit_cnt=0, in_ready=1.
- Truth sweep, defaults (WIDTH=8, N_IN=2, STAGES=2):
  - AND of 8'hF0, 8'h3C -> y=8'h30.
  - XOR of the same operands -> 8'hCC.
  - NOR of the same operands -> 8'h03.
  - Each result arrives 2 cycles after presentation.
- Reserved op: op=3'b110 with any operands -> y=0, op_err=1.
  - The next beat with op=000 -> op_err=0.
- Backpressure: stream 5 beats back-to-back, drop out_ready for 3 cycles mid-stream.
  - in_ready low in exactly those cycles.
  - All 5 results arrive in order with none lost or duplicated.
  - y stays stable while stalled.
- Mid-operation reset: assert rst_n low with 2 beats in flight.
  - out_valid drops in the same cycle.
  - The beats never appear after release.
- With GATE_PIPE_STATS_EN: 3 AND beats of 8'hFF/8'hFF plus 1 beat of 8'hFF/8'h7F.
  - hit_cnt=3.
  - Pulse cnt_clr coincident with a fourth all-ones transfer -> hit_cnt=0.

Source files
------------

// File: rtl/gate_pipe.sv
// ============================================================================
// Module   : gate_pipe
// Purpose  : Pipelined N-input bitwise gate, selectable op, valid/ready on both
//            sides. Optional hit counter built when GATE_PIPE_STATS_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int N_IN   = 2,
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [2:0]            op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      y,
  output logic                  op_err,
  output logic [15:0]           hit_cnt,
  input  logic                  cnt_clr
);

  localparam logic [2:0] c_OP_AND  = 3'b000;
  localparam logic [2:0] c_OP_OR   = 3'b001;
  localparam logic [2:0] c_OP_XOR  = 3'b010;
  localparam logic [2:0] c_OP_NAND = 3'b011;
  localparam logic [2:0] c_OP_NOR  = 3'b100;
  localparam logic [2:0] c_OP_XNOR = 3'b101;

  logic [WIDTH-1:0] w_and;
  logic [WIDTH-1:0] w_or;
  logic [WIDTH-1:0] w_xor;
  logic [WIDTH-1:0] w_res;
  logic             w_err;
  logic             w_en;

  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_y   [STAGES];
  logic             r_err [STAGES];

  always_comb begin
    w_and = '1;
    w_or  = '0;
    w_xor = '0;
    for (int k = 0; k < N_IN; k++) begin
      w_and = w_and & in_data[k*WIDTH +: WIDTH];
      w_or  = w_or  | in_data[k*WIDTH +: WIDTH];
      w_xor = w_xor ^ in_data[k*WIDTH +: WIDTH];
    end
    w_res = '0;
    w_err = 1'b0;
    case (op)
      c_OP_AND:  w_res = w_and;
      c_OP_OR:   w_res = w_or;
      c_OP_XOR:  w_res = w_xor;
      c_OP_NAND: w_res = ~w_and;
      c_OP_NOR:  w_res = ~w_or;
      c_OP_XNOR: w_res = ~w_xor;
      default:   w_err = 1'b1;
    endcase
  end

  // One enable for the whole pipe: bubbles are never squeezed out.
  assign w_en     = ~r_vld[STAGES-1] | out_ready;
  assign in_ready = w_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_vld[s] <= 1'b0;
        r_y[s]   <= '0;
        r_err[s] <= 1'b0;
      end
    end else if (w_en) begin
      r_vld[0] <= in_valid;
      r_y[0]   <= w_res;
      r_err[0] <= w_err;
      for (int s = 1; s < STAGES; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_y[s]   <= r_y[s-1];
        r_err[s] <= r_err[s-1];
      end
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign y         = r_y[STAGES-1];
  assign op_err    = r_err[STAGES-1];

`ifdef GATE_PIPE_STATS_EN
  logic [15:0] r_hit;

  // Clear wins over a same-cycle increment; the count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit <= '0;
    end else if (cnt_clr) begin
      r_hit <= '0;
    end else if (out_valid && out_ready && (&y) && !op_err && (r_hit != 16'hFFFF)) begin
      r_hit <= r_hit + 16'd1;
    end
  end

  assign hit_cnt = r_hit;
`else
  logic w_unused_clr;
  assign w_unused_clr = cnt_clr;
  assign hit_cnt      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gate_pipe.sv
// ============================================================================
// Module   : tb_gate_pipe
// Purpose  : Self-checking bench for gate_pipe (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_pipe;

  localparam int W = 8;
  localparam int N = 2;
  localparam int S = 2;

`ifdef GATE_PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic [2:0]     op;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   y;
  logic           op_err;
  logic [15:0]    hit_cnt;
  logic           cnt_clr;

  int n_tests = 0;
  int n_fail  = 0;

  gate_pipe #(.WIDTH(W), .N_IN(N), .STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .op_err   (op_err),
    .hit_cnt  (hit_cnt),
    .cnt_clr  (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_y;
    logic         exp_err;
  } vec_t;

  typedef struct {
    bit           v;
    logic [W-1:0] y;
    bit           e;
  } slot_t;

  vec_t  tbl [10];
  slot_t pipe [$];
  int    exp_hit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Per-bit population count across operands decides each result bit.
  function automatic slot_t model(input logic [2:0] o, input logic [N*W-1:0] d);
    slot_t r;
    int    ones;
    r.v = 1'b1;
    r.e = (o >= 3'd6);
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int k = 0; k < N; k++) ones += int'(d[k*W + b]);
      case (o)
        3'd0:    r.y[b] = (ones == N);
        3'd1:    r.y[b] = (ones > 0);
        3'd2:    r.y[b] = (ones % 2 == 1);
        3'd3:    r.y[b] = (ones != N);
        3'd4:    r.y[b] = (ones == 0);
        3'd5:    r.y[b] = (ones % 2 == 0);
        default: r.y[b] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    slot_t z;
    z.v = 1'b0; z.y = '0; z.e = 1'b0;
    pipe.delete();
    for (int s = 0; s < S; s++) pipe.push_back(z);
    exp_hit = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send1(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    op       = o;
    in_data  = {b, a};
  endtask

  // One random cycle compared against the queue model; call at posedge+1.
  task automatic rand_cycle(input bit drain);
    slot_t nxt;
    bit    en;
    bit    xfer;
    if (drain) begin
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
    end else begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      cnt_clr   = ($urandom_range(0, 39) == 0);
      op        = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) in_data = '1;
      else                           in_data = N*W'($urandom);
    end
    @(negedge clk);
    en   = !pipe[0].v || out_ready;
    xfer = pipe[0].v && out_ready;
    chk("rnd_in_ready", in_ready, en);
    chk("rnd_out_valid", out_valid, pipe[0].v);
    if (pipe[0].v) begin
      chk("rnd_y", y, pipe[0].y);
      chk("rnd_op_err", op_err, pipe[0].e);
    end
    chk("rnd_hit_cnt", hit_cnt, exp_hit);
    if (STATS) begin
      if (cnt_clr) exp_hit = 0;
      else if (xfer && pipe[0].y == '1 && !pipe[0].e && exp_hit < 16'hFFFF) exp_hit++;
    end
    if (en) begin
      nxt   = model(op, in_data);
      nxt.v = in_valid;
      void'(pipe.pop_front());
      pipe.push_back(nxt);
    end
    next_cyc();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    op        = 3'd0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;

    tbl[0] = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0};
    tbl[1] = '{3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0};
    tbl[2] = '{3'b010, 8'hF0, 8'h3C, 8'hCC, 1'b0};
    tbl[3] = '{3'b011, 8'hF0, 8'h3C, 8'hCF, 1'b0};
    tbl[4] = '{3'b100, 8'hF0, 8'h3C, 8'h03, 1'b0};
    tbl[5] = '{3'b101, 8'hF0, 8'h3C, 8'h33, 1'b0};
    tbl[6] = '{3'b110, 8'hA5, 8'h5A, 8'h00, 1'b1};
    tbl[7] = '{3'b000, 8'hFF, 8'h0F, 8'h0F, 1'b0};
    tbl[8] = '{3'b111, 8'hFF, 8'hFF, 8'h00, 1'b1};
    tbl[9] = '{3'b001, 8'h00, 8'h00, 8'h00, 1'b0};

    // Reset state
    next_cyc();
    next_cyc();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_y", y, 8'h00);
    chk("rst_op_err", op_err, 1'b0);
    chk("rst_hit_cnt", hit_cnt, 16'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    next_cyc();
    rst_n = 1'b1;
    model_reset();

    // Truth table, one isolated beat at a time, exact latency
    for (int i = 0; i < 10; i++) begin
      send1(tbl[i].op, tbl[i].a, tbl[i].b);
      next_cyc();
      in_valid = 1'b0;
      @(negedge clk);
      chk("tbl_early", out_valid, 1'b0);
      next_cyc();
      @(negedge clk);
      chk("tbl_valid", out_valid, 1'b1);
      chk("tbl_y", y, tbl[i].exp_y);
      chk("tbl_err", op_err, tbl[i].exp_err);
      next_cyc();
    end
    next_cyc();

    // Backpressure: 5 beats streamed, out_ready low in cycles 3..5
    begin
      logic [W-1:0] exp_y [5];
      logic [W-1:0] held;
      bit           stalled_prev;
      int           sent;
      int           got;
      sent = 0; got = 0; stalled_prev = 1'b0; held = '0;
      for (int k = 0; k < 5; k++) exp_y[k] = W'(8'h11 * (k + 1)) ^ 8'h0F;
      for (int c = 0; c < 30 && got < 5; c++) begin
        in_valid  = (sent < 5);
        op        = 3'b010;
        in_data   = {8'h0F, W'(8'h11 * (sent + 1))};
        out_ready = !(c >= 3 && c <= 5);
        @(negedge clk);
        chk("bp_in_ready", in_ready, !(c >= 3 && c <= 5));
        if (stalled_prev) chk("bp_hold", y, held);
        if (out_valid && out_ready) begin
          chk("bp_y", y, exp_y[got]);
          got++;
        end
        stalled_prev = out_valid && !out_ready;
        held         = y;
        if (in_valid && in_ready) sent++;
        next_cyc();
      end
      chk("bp_count", got, 5);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      next_cyc();
      @(negedge clk);
      chk("bp_no_dup", out_valid, 1'b0);
      next_cyc();
    end

    // Reset with two beats in flight
    send1(3'b001, 8'h12, 8'h34);
    next_cyc();
    send1(3'b001, 8'h56, 8'h78);
    next_cyc();
    in_valid = 1'b0;
    chk("mrst_pre_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_async_valid", out_valid, 1'b0);
    chk("mrst_in_ready", in_ready, 1'b1);
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("mrst_flushed", out_valid, 1'b0);
      next_cyc();
    end

    // Hit counter: 3 all-ones AND beats + one that is not all ones
    send1(3'b000, 8'hFF, 8'hFF);
    next_cyc();
    next_cyc();
    next_cyc();
    send1(3'b000, 8'hFF, 8'h7F);
    next_cyc();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) next_cyc();
    @(negedge clk);
    chk("hit_three", hit_cnt, STATS ? 16'd3 : 16'd0);
    next_cyc();
    send1(3'b000, 8'hFF, 8'hFF);
    next_cyc();
    in_valid = 1'b0;
    next_cyc();
    @(negedge clk);
    chk("hit_clr_xfer_valid", out_valid, 1'b1);
    chk("hit_clr_xfer_y", y, 8'hFF);
    cnt_clr = 1'b1;
    next_cyc();
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("hit_clr_wins", hit_cnt, 16'd0);
    next_cyc();

    // Random traffic against the queue model, then drain
    do_reset();
    for (int c = 0; c < 600; c++) rand_cycle(1'b0);
    for (int c = 0; c < S + 3; c++) rand_cycle(1'b1);
    chk("rnd_drained", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
